// File: rtl/tt_sub_pkg.sv
// Shared definitions for the bit-serial subtractor tile.
//   state_t      : operation sequencing states
//   ui_in bits   : A_BIT, B_BIT, VALID_BIT, START_BIT, LAST_BIT
//   uo_out bits  : DIFF_BIT, BORROW_BIT, OUT_VALID_BIT, DONE_BIT, COUNT_LSB (4-bit field)
package tt_sub_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned A_BIT     = 0;
  localparam int unsigned B_BIT     = 1;
  localparam int unsigned VALID_BIT = 2;
  localparam int unsigned START_BIT = 3;
  localparam int unsigned LAST_BIT  = 4;

  localparam int unsigned DIFF_BIT      = 0;
  localparam int unsigned BORROW_BIT    = 1;
  localparam int unsigned OUT_VALID_BIT = 2;
  localparam int unsigned DONE_BIT      = 3;
  localparam int unsigned COUNT_LSB     = 4;

endpackage

// File: rtl/half_sub.sv
// Half-subtractor cell: x - y.
//   x, y   : operand bits
//   diff   : x ^ y
//   borrow : ~x & y
module half_sub (
  input  logic x,
  input  logic y,
  output logic diff,
  output logic borrow
);

  assign diff   = x ^ y;
  assign borrow = ~x & y;

endmodule

// File: rtl/tt_um_serial_sub.sv
// Tiny Tapeout tile: bit-serial subtractor A - B, LSB first.
//   clk, rst_n : tile clock, asynchronous active-low reset
//   ena        : tile enable; low freezes all state
//   ui_in      : [0]=a [1]=b [2]=valid [3]=start [4]=last
//   uo_out     : [0]=diff [1]=borrow [2]=out_valid [3]=done [7:4]=accepted bit count
//   uio_in     : unused
//   uio_out    : result word while done, else 0
//   uio_oe     : 8'hFF while done, else 8'h00
module tt_um_serial_sub
  import tt_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_t             state_q, state_d;
  logic               borrow_q, diff_q, ov_q;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [3:0]         count_q, count_d;

  logic a, b, valid, start, last;
  logic accept, bin, d, bout, finish;
  logic d1, b1, b2;
  logic [3:0] cnt_base;
  logic [7:0] result_ext;
  logic done;

  logic unused_ok;
  assign unused_ok = &{1'b0, uio_in, ui_in[7:5]};

  assign a     = ui_in[A_BIT];
  assign b     = ui_in[B_BIT];
  assign valid = ui_in[VALID_BIT];
  assign start = ui_in[START_BIT];
  assign last  = ui_in[LAST_BIT];

  // start discards any borrow carried from a previous operation
  assign bin = start ? 1'b0 : borrow_q;

  half_sub u_hs0 (.x(a),  .y(b),   .diff(d1), .borrow(b1));
  half_sub u_hs1 (.x(d1), .y(bin), .diff(d),  .borrow(b2));
  assign bout = b1 | b2;

  assign accept   = ena & valid & ((state_q == RUN) | start);
  assign cnt_base = start ? 4'd0 : count_q;
  assign finish   = last | (cnt_base == 4'(WIDTH - 1));

  always_comb begin
    state_d = state_q;
    if (accept) state_d = finish ? DONE : RUN;
  end

  always_comb begin
    result_d = start ? '0 : result_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (cnt_base == 4'(i)) result_d[i] = d;
    end
    if (start)                count_d = 4'd1;
    else if (count_q == 4'hF) count_d = count_q;
    else                      count_d = count_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      borrow_q <= 1'b0;
      diff_q   <= 1'b0;
      ov_q     <= 1'b0;
      result_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      ov_q    <= accept;
      if (accept) begin
        diff_q   <= d;
        borrow_q <= bout;
        result_q <= result_d;
        count_q  <= count_d;
      end
    end
  end

  assign done = (state_q == DONE);

  always_comb begin
    result_ext              = '0;
    result_ext[WIDTH-1:0]   = result_q;
    uo_out                  = '0;
    uo_out[DIFF_BIT]        = diff_q;
    uo_out[BORROW_BIT]      = borrow_q;
    // gated by ena so a pulse pending when the tile is frozen never shows
    uo_out[OUT_VALID_BIT]   = ov_q & ena;
    uo_out[DONE_BIT]        = done;
    uo_out[COUNT_LSB +: 4]  = count_q;
    uio_out                 = done ? result_ext : 8'h00;
    uio_oe                  = done ? 8'hFF : 8'h00;
  end

endmodule

// File: tb/tb_tt_um_serial_sub.sv
module tb_tt_um_serial_sub;

  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = '0;
  logic [7:0] uio_in = '0;
  logic [7:0] uo_out, uio_out, uio_oe;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  tt_um_serial_sub #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
    .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: operands accumulated as integers, outputs derived arithmetically.
  int unsigned m_a = 0, m_b = 0, m_n = 0, m_res = 0;
  bit m_active = 0, m_done = 0, m_diff = 0, m_borrow = 0, m_ov = 0;

  always @(negedge rst_n) begin
    m_a = 0; m_b = 0; m_n = 0; m_res = 0;
    m_active = 0; m_done = 0; m_diff = 0; m_borrow = 0; m_ov = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc;
      acc = ena & ui_in[2] & (m_active | ui_in[3]);
      m_ov = acc;
      if (acc) begin
        if (ui_in[3]) begin m_a = 0; m_b = 0; m_n = 0; end
        m_a = m_a | (32'(ui_in[0]) << m_n);
        m_b = m_b | (32'(ui_in[1]) << m_n);
        m_n = m_n + 1;
        m_res = (m_a - m_b) & ((32'd1 << m_n) - 1);
        m_diff = m_res[m_n-1];
        m_borrow = (m_a < m_b);
        if (ui_in[4] || m_n == WIDTH) begin m_done = 1; m_active = 0; end
        else begin m_done = 0; m_active = 1; end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rst_n && chk_en) begin
      logic [7:0] e_uo;
      e_uo = {m_n[3:0], m_done, m_ov & ena, m_borrow, m_diff};
      chk("model_uo_out", {24'd0, uo_out}, {24'd0, e_uo});
      chk("model_uio_out", {24'd0, uio_out}, m_done ? m_res : 32'd0);
      chk("model_uio_oe", {24'd0, uio_oe}, m_done ? 32'hFF : 32'd0);
    end
  end

  task automatic bit_in(input logic a, input logic b, input logic v,
                        input logic s, input logic l, input logic e);
    @(negedge clk);
    ui_in = {3'b000, l, s, v, b, a};
    ena = e;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) bit_in(0, 0, 0, 0, 0, 1);
  endtask

  task automatic op(input logic [7:0] a, input logic [7:0] b, input int n,
                    input bit use_last, output logic [7:0] stream);
    stream = '0;
    for (int i = 0; i < n; i++) begin
      bit_in(a[i], b[i], 1, i == 0, use_last && (i == n - 1), 1);
      stream[i] = uo_out[0];
    end
  endtask

  logic [7:0] s;

  initial begin
    #1;
    chk("reset_uo_out", {24'd0, uo_out}, 0);
    chk("reset_uio_out", {24'd0, uio_out}, 0);
    chk("reset_uio_oe", {24'd0, uio_oe}, 0);
    #12 rst_n = 1'b1;
    chk_en = 1'b1;
    idle_cyc(2);

    // valid without start in IDLE is ignored
    bit_in(1, 0, 1, 0, 0, 1);
    bit_in(1, 1, 1, 0, 1, 1);
    chk("idle_ignore_uo", {24'd0, uo_out}, 0);
    chk("idle_ignore_uio", {24'd0, uio_out}, 0);

    // 5 - 3
    op(8'h05, 8'h03, 8, 1, s);
    chk("t1_stream", {24'd0, s}, 32'h02);
    chk("t1_result", {24'd0, uio_out}, 32'h02);
    chk("t1_oe", {24'd0, uio_oe}, 32'hFF);
    chk("t1_done", {31'd0, uo_out[3]}, 1);
    chk("t1_borrow", {31'd0, uo_out[1]}, 0);
    chk("t1_count", {28'd0, uo_out[7:4]}, 8);

    // 3 - 5, then done held while valid without start arrives
    op(8'h03, 8'h05, 8, 1, s);
    chk("t2_result", {24'd0, uio_out}, 32'hFE);
    chk("t2_borrow", {31'd0, uo_out[1]}, 1);
    bit_in(1, 0, 1, 0, 0, 1);
    idle_cyc(2);
    chk("t2_done_held", {31'd0, uo_out[3]}, 1);
    chk("t2_result_held", {24'd0, uio_out}, 32'hFE);

    // 4-bit 9 - 3
    op(8'h09, 8'h03, 4, 1, s);
    chk("t3_result", {24'd0, uio_out}, 32'h06);
    chk("t3_count", {28'd0, uo_out[7:4]}, 4);

    // auto-finish after 8 bits without last
    op(8'hC8, 8'h64, 8, 0, s);
    chk("t4_done", {31'd0, uo_out[3]}, 1);
    chk("t4_result", {24'd0, uio_out}, 32'h64);
    chk("t4_borrow", {31'd0, uo_out[1]}, 0);

    // gaps and ena hold: 200 - 100
    for (int i = 0; i < 4; i++) bit_in(8'hC8 >> i, 8'h64 >> i, 1, i == 0, 0, 1);
    idle_cyc(3);
    bit_in(1, 0, 1, 1, 0, 0);
    bit_in(0, 1, 1, 0, 1, 0);
    chk("t5_hold_ov", {31'd0, uo_out[2]}, 0);
    chk("t5_hold_count", {28'd0, uo_out[7:4]}, 4);
    chk("t5_hold_done", {31'd0, uo_out[3]}, 0);
    for (int i = 4; i < 8; i++) bit_in(8'hC8 >> i, 8'h64 >> i, 1, 0, i == 7, 1);
    chk("t5_result", {24'd0, uio_out}, 32'h64);

    // async reset mid-operation
    for (int i = 0; i < 5; i++) bit_in(1, 0, 1, i == 0, 0, 1);
    ui_in = '0;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_uo", {24'd0, uo_out}, 0);
    chk("t6_rst_uio", {24'd0, uio_out}, 0);
    chk("t6_rst_oe", {24'd0, uio_oe}, 0);
    @(negedge clk) rst_n = 1'b1;
    idle_cyc(1);
    op(8'h01, 8'h01, 8, 1, s);
    chk("t6_result", {24'd0, uio_out}, 32'h00);
    chk("t6_borrow", {31'd0, uo_out[1]}, 0);

    // start reasserted in RUN restarts the operation
    for (int i = 0; i < 3; i++) bit_in(0, 1, 1, i == 0, 0, 1);
    op(8'h0F, 8'h01, 8, 1, s);
    chk("t6_restart_result", {24'd0, uio_out}, 32'h0E);
    chk("t6_restart_count", {28'd0, uo_out[7:4]}, 8);

    idle_cyc(2);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
